// File: rtl/lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_pkg: funct3 codes, FSM encoding and load extension for lsu_mem_stage.   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_RMW_WR = 3'd1;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam logic [ST_W-1:0] ST_SPL_HI  = 3'd2;
  localparam logic [ST_W-1:0] ST_SPL_WLO = 3'd3;
  localparam logic [ST_W-1:0] ST_SPL_WHI = 3'd4;
`endif

  // window is {word w+1, word w}; offset selects the first byte inside word w
  function automatic logic [31:0] ext_load(input logic [63:0] window,
                                           input logic [1:0]  offset,
                                           input logic [2:0]  funct3);
    logic [31:0] s;
    s = 32'(window >> {offset, 3'b000});
    case (funct3)
      F3_B:    ext_load = {{24{s[7]}}, s[7:0]};
      F3_H:    ext_load = {{16{s[15]}}, s[15:0]};
      F3_BU:   ext_load = {24'b0, s[7:0]};
      F3_HU:   ext_load = {16'b0, s[15:0]};
      default: ext_load = s;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_lane_align: byte-lane merge for stores and extraction for loads.        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] old_lo,
  input  logic [31:0] old_hi,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  input  logic [31:0] store_data,
  output logic [31:0] new_lo,
  output logic [31:0] new_hi,
  output logic [31:0] load_val
);

  logic [63:0] window;
  logic [63:0] mask;
  logic [63:0] data;
  logic [63:0] merged;

  always_comb begin
    window = {old_hi, old_lo};
    case (funct3[1:0])
      2'b00:   mask = 64'h0000_0000_0000_00FF;
      2'b01:   mask = 64'h0000_0000_0000_FFFF;
      default: mask = 64'h0000_0000_FFFF_FFFF;
    endcase
    mask     = mask << {offset, 3'b000};
    data     = {32'b0, store_data} << {offset, 3'b000};
    merged   = (window & ~mask) | (data & mask);
    new_lo   = merged[31:0];
    new_hi   = merged[63:32];
    load_val = ext_load(window, offset, funct3);
  end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lsu_mem_stage: RV32I MEM-stage LSU over a word-only dm (RMW for SB/SH).     |
// | Define LSU_MISALIGN_SPLIT_EN to split misaligned ops across two words.      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int DM_AW = 10
) (
  input  logic             clka,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [31:0]      req_inst,
  output logic             rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_fault,
  output logic             dm_we,
  output logic [DM_AW-1:0] dm_addr,
  output logic [31:0]      dm_wdata,
  input  logic [31:0]      dm_rdata,
  output logic [31:0]      dm_inst
);

  logic [ST_W-1:0]  state_q, state_d;
  logic [DM_AW-1:0] addr_q, addr_d;
  logic [1:0]       off_q, off_d;
  logic [2:0]       f3_q, f3_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      inst_q, inst_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_fault_q, rsp_fault_d;

  logic [DM_AW-1:0] req_word;
  logic             accept, illegal, misalign, op_fault, we_raw;
  logic [1:0]       al_off;
  logic [2:0]       al_f3;
  logic [31:0]      al_lo, al_wdata, merged_lo, merged_hi, load_val;
  logic             unused_addr_hi;

  assign req_word       = req_addr[DM_AW+1:2];
  assign unused_addr_hi = ^req_addr[31:DM_AW+2];
  assign req_ready      = (state_q == ST_IDLE) && !rsp_valid_q;
  assign accept         = req_valid && req_ready;
  assign illegal  = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                    (req_we && ((req_funct3 == F3_BU) || (req_funct3 == F3_HU)));
  assign misalign = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0]) ||
                    ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));

`ifdef LSU_MISALIGN_SPLIT_EN
  logic             we_q, we_d;
  logic [31:0]      hi_q, hi_d;
  logic [DM_AW-1:0] addr_nxt;
  assign addr_nxt = addr_q + {{(DM_AW-1){1'b0}}, 1'b1};
  assign op_fault = illegal;
`else
  logic [31:0] unused_merged_hi;
  assign unused_merged_hi = merged_hi;
  assign op_fault = illegal | misalign;
`endif

  // IDLE merges against the word being read now; later states use the latched op
  assign al_lo    = (state_q == ST_IDLE) ? dm_rdata       : lo_q;
  assign al_off   = (state_q == ST_IDLE) ? req_addr[1:0]  : off_q;
  assign al_f3    = (state_q == ST_IDLE) ? req_funct3     : f3_q;
  assign al_wdata = (state_q == ST_IDLE) ? req_wdata      : wdata_q;

  lsu_lane_align u_align (
    .old_lo     (al_lo),
    .old_hi     (dm_rdata),
    .offset     (al_off),
    .funct3     (al_f3),
    .store_data (al_wdata),
    .new_lo     (merged_lo),
    .new_hi     (merged_hi),
    .load_val   (load_val)
  );

  always_ff @(posedge clka) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      off_q       <= '0;
      f3_q        <= '0;
      wdata_q     <= '0;
      lo_q        <= '0;
      inst_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_fault_q <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      we_q        <= 1'b0;
      hi_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      off_q       <= off_d;
      f3_q        <= f3_d;
      wdata_q     <= wdata_d;
      lo_q        <= lo_d;
      inst_q      <= inst_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_fault_q <= rsp_fault_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      we_q        <= we_d;
      hi_q        <= hi_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    off_d       = off_q;
    f3_d        = f3_q;
    wdata_d     = wdata_q;
    lo_d        = lo_q;
    inst_d      = inst_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_fault_d = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
    we_d        = we_q;
    hi_d        = hi_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = req_word;
          off_d   = req_addr[1:0];
          f3_d    = req_funct3;
          wdata_d = req_wdata;
          inst_d  = req_inst;
`ifdef LSU_MISALIGN_SPLIT_EN
          we_d    = req_we;
`endif
          if (op_fault) begin
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
`ifdef LSU_MISALIGN_SPLIT_EN
          end else if (misalign) begin
            lo_d    = dm_rdata;
            state_d = ST_SPL_HI;
`endif
          end else if (!req_we) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = load_val;
          end else if (req_funct3 == F3_W) begin
            rsp_valid_d = 1'b1;
          end else begin
            lo_d    = merged_lo;
            state_d = ST_RMW_WR;
          end
        end
      end
      ST_RMW_WR: begin
        rsp_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ST_SPL_HI: begin
        if (!we_q) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_val;
          state_d     = ST_IDLE;
        end else begin
          lo_d    = merged_lo;
          hi_d    = merged_hi;
          state_d = ST_SPL_WLO;
        end
      end
      ST_SPL_WLO: state_d = ST_SPL_WHI;
      ST_SPL_WHI: begin
        rsp_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dm_addr  = req_word;
    dm_wdata = req_wdata;
    dm_inst  = inst_q;
    we_raw   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        dm_inst = req_inst;
        we_raw  = accept && req_we && (req_funct3 == F3_W) && !misalign;
      end
      ST_RMW_WR: begin
        dm_addr  = addr_q;
        dm_wdata = lo_q;
        we_raw   = 1'b1;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      ST_SPL_HI:  dm_addr = addr_nxt;
      ST_SPL_WLO: begin
        dm_addr  = addr_q;
        dm_wdata = lo_q;
        we_raw   = 1'b1;
      end
      ST_SPL_WHI: begin
        dm_addr  = addr_nxt;
        dm_wdata = hi_q;
        we_raw   = 1'b1;
      end
`endif
      default: we_raw = 1'b0;
    endcase
    // a reset mid-operation must never leave a partial write behind
    dm_we = we_raw & rstn;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_fault = rsp_fault_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_lsu_mem_stage: directed and random checks against a byte-level model.    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_lsu_mem_stage;

  localparam int DM_AW = 10;
  localparam int NW    = 1 << DM_AW;
  localparam int NB    = 4 * NW;

  logic             clka = 1'b0;
  logic             rstn = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic             req_we = 1'b0;
  logic [2:0]       req_funct3 = 3'b0;
  logic [31:0]      req_addr = 32'b0;
  logic [31:0]      req_wdata = 32'b0;
  logic [31:0]      req_inst = 32'b0;
  logic             rsp_valid;
  logic [31:0]      rsp_rdata;
  logic             rsp_fault;
  logic             dm_we;
  logic [DM_AW-1:0] dm_addr;
  logic [31:0]      dm_wdata;
  logic [31:0]      dm_rdata;
  logic [31:0]      dm_inst;

  always #5 clka = ~clka;

  lsu_mem_stage #(.DM_AW(DM_AW)) dut (
    .clka(clka), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_inst(req_inst),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_inst(dm_inst)
  );

  // data memory: combinational read, write on posedge; tb port for preloading
  logic [31:0]      dm_mem [0:NW-1];
  logic             tb_we = 1'b0;
  logic [DM_AW-1:0] tb_wa = '0;
  logic [31:0]      tb_wd = 32'b0;
  int               we_cnt = 0;
  int               b2b = 0;
  logic             prev_rv = 1'b0;
  logic [DM_AW-1:0] last_wa = '0;

  assign dm_rdata = dm_mem[dm_addr];

  always @(posedge clka) begin
    if (dm_we) begin
      dm_mem[dm_addr] <= dm_wdata;
      we_cnt          <= we_cnt + 1;
      last_wa         <= dm_addr;
    end else if (tb_we) begin
      dm_mem[tb_wa] <= tb_wd;
    end
    if (rsp_valid && prev_rv) b2b <= b2b + 1;
    prev_rv <= rsp_valid;
  end

  logic [7:0] ref_b [0:NB-1];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic poke(input int w, input logic [31:0] v);
    @(negedge clka);
    tb_we = 1'b1; tb_wa = w[DM_AW-1:0]; tb_wd = v;
    @(negedge clka);
    tb_we = 1'b0;
    for (int i = 0; i < 4; i++) ref_b[4*w+i] = v[8*i +: 8];
  endtask

  // Architectural model: byte-addressed memory, RV32I semantics
  task automatic model_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic e_fault,
                          output logic [31:0] e_rd, output int e_lat, output int e_nwe);
    int size, a;
    logic ill, mis;
    logic [31:0] v;
    ill  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && (f3 == 3'd4 || f3 == 3'd5));
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    a    = int'(addr[DM_AW+1:0]);
    mis  = (a % size) != 0;
    e_rd = 32'b0; e_nwe = 0; e_lat = 1;
`ifdef LSU_MISALIGN_SPLIT_EN
    e_fault = ill;
`else
    e_fault = ill || mis;
`endif
    if (!e_fault) begin
      if (we) begin
        for (int i = 0; i < size; i++) ref_b[(a+i) % NB] = wd[8*i +: 8];
        e_nwe = mis ? 2 : 1;
        e_lat = mis ? 4 : ((size == 4) ? 1 : 2);
      end else begin
        v = 32'b0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = ref_b[(a+i) % NB];
        if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
        e_rd  = v;
        e_lat = mis ? 2 : 1;
      end
    end
  endtask

  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output logic got_rv, output logic got_flt,
                       output logic [31:0] got_rd, output int lat, output int nwe,
                       output logic busy_ok);
    int guard, w0;
    @(negedge clka);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr;
    req_wdata = wd; req_inst = $urandom;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clka);
      guard++;
    end
    w0 = we_cnt;
    @(posedge clka); #1;
    req_valid = 1'b0;
    lat = 1; busy_ok = 1'b1;
    while (!rsp_valid && lat < 8) begin
      if (req_ready) busy_ok = 1'b0;
      @(posedge clka); #1;
      lat++;
    end
    got_rv = rsp_valid; got_flt = rsp_fault; got_rd = rsp_rdata;
    @(negedge clka);
    nwe = we_cnt - w0;
  endtask

  task automatic run_chk(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic flt, output int lat);
    logic e_fault, rv, bok;
    logic [31:0] e_rd;
    int e_lat, e_nwe, nwe;
    model_op(we, f3, addr, wd, e_fault, e_rd, e_lat, e_nwe);
    do_op(we, f3, addr, wd, rv, flt, rd, lat, nwe, bok);
    check_eq({tag, " valid"},   32'(rv),  32'd1);
    check_eq({tag, " fault"},   32'(flt), 32'(e_fault));
    check_eq({tag, " rdata"},   rd, e_rd);
    check_eq({tag, " latency"}, lat, e_lat);
    check_eq({tag, " writes"},  nwe, e_nwe);
    check_eq({tag, " busy"},    32'(bok), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  logic [31:0] rd;
  logic        flt;
  int          lat, w0, nbad;
  logic [2:0]  ld_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [2:0]  st_f3 [3] = '{3'd0, 3'd1, 3'd2};

  initial begin
    for (int w = 0; w < NW; w++) poke(w, $urandom);

    @(negedge clka);
    check_eq("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("reset rsp_rdata", rsp_rdata, 32'd0);
    check_eq("reset rsp_fault", 32'(rsp_fault), 32'd0);
    check_eq("reset dm_we", 32'(dm_we), 32'd0);
    rstn = 1'b1;
    @(posedge clka); #1;
    check_eq("reset req_ready", 32'(req_ready), 32'd1);

    run_chk("sw", 1'b1, 3'd2, 32'h010, 32'hDEADBEEF, rd, flt, lat);
    check_eq("sw addr", 32'(last_wa), 32'd4);
    run_chk("lw", 1'b0, 3'd2, 32'h010, 32'h0, rd, flt, lat);
    check_eq("lw value", rd, 32'hDEADBEEF);

    poke(4, 32'h11223344);
    run_chk("sb", 1'b1, 3'd0, 32'h012, 32'h123456AA, rd, flt, lat);
    check_eq("sb latency", lat, 32'd2);
    check_eq("sb word", dm_mem[4], 32'h11AA3344);

    poke(4, 32'h80FF7F01);
    run_chk("lb", 1'b0, 3'd0, 32'h013, 32'h0, rd, flt, lat);
    check_eq("lb value", rd, 32'hFFFFFF80);
    run_chk("lbu", 1'b0, 3'd4, 32'h013, 32'h0, rd, flt, lat);
    check_eq("lbu value", rd, 32'h00000080);
    run_chk("lh", 1'b0, 3'd1, 32'h010, 32'h0, rd, flt, lat);
    check_eq("lh value", rd, 32'h00007F01);
    run_chk("lhu", 1'b0, 3'd5, 32'h012, 32'h0, rd, flt, lat);
    check_eq("lhu value", rd, 32'h000080FF);

    poke(4, 32'h44332211);
    poke(5, 32'h88776655);
    run_chk("lw mis", 1'b0, 3'd2, 32'h011, 32'h0, rd, flt, lat);
`ifdef LSU_MISALIGN_SPLIT_EN
    check_eq("lw mis value", rd, 32'h55443322);
    check_eq("lw mis latency", lat, 32'd2);
`else
    check_eq("lw mis fault", 32'(flt), 32'd1);
    check_eq("lw mis value", rd, 32'd0);
`endif

    poke(0, 32'h33221100);
    poke(1, 32'h77665544);
    poke(NW-1, 32'hAABBCCDD);
    run_chk("sh mis", 1'b1, 3'd1, 32'h003, 32'h0000BEEF, rd, flt, lat);
    run_chk("sh wrap", 1'b1, 3'd1, 32'hFFF, 32'h00001234, rd, flt, lat);
`ifdef LSU_MISALIGN_SPLIT_EN
    check_eq("sh mis w0", dm_mem[0], 32'hEF221112);
    check_eq("sh mis w1", dm_mem[1], 32'h776655BE);
    check_eq("sh wrap top", dm_mem[NW-1], 32'h34BBCCDD);
    check_eq("sh wrap addr", 32'(last_wa), 32'd0);
`else
    check_eq("sh mis fault", 32'(flt), 32'd1);
    check_eq("sh mis w0", dm_mem[0], 32'h33221100);
`endif

    poke(4, 32'h11223344);
    @(negedge clka);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h010; req_wdata = 32'h55;
    @(posedge clka); #1;
    req_valid = 1'b0;
    check_eq("rst rmw we pre", 32'(dm_we), 32'd1);
    w0 = we_cnt;
    rstn = 1'b0;
    #1;
    check_eq("rst rmw we gated", 32'(dm_we), 32'd0);
    @(posedge clka); #1;
    rstn = 1'b1;
    check_eq("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst req_ready", 32'(req_ready), 32'd1);
    @(negedge clka);
    check_eq("rst no write", we_cnt - w0, 32'd0);
    check_eq("rst word", dm_mem[4], 32'h11223344);

    run_chk("f3 011", 1'b0, 3'd3, 32'h020, 32'h0, rd, flt, lat);
    check_eq("f3 011 fault", 32'(flt), 32'd1);
    run_chk("sbu illegal", 1'b1, 3'd4, 32'h020, 32'hFF, rd, flt, lat);

    for (int n = 0; n < 400; n++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
      else if (we) f3 = st_f3[$urandom_range(0, 2)];
      else f3 = ld_f3[$urandom_range(0, 4)];
      if ($urandom_range(0, 3) == 0) addr = 32'(NB - 64 + $urandom_range(0, 63));
      else addr = 32'($urandom_range(0, 127));
      addr = addr | ($urandom & ~32'(NB - 1));
      run_chk("rnd", we, f3, addr, $urandom, rd, flt, lat);
    end

    nbad = 0;
    for (int w = 0; w < NW; w++)
      if (dm_mem[w] !== {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]}) nbad++;
    check_eq("mem image", nbad, 32'd0);
    check_eq("b2b rsp_valid", b2b, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
